alu_modul: RTL and testbench

//  Registered 32-bit ALU for the I-type datapath of the single-issue MIPS core.

---
 rtl/alu_modul.sv | 148 ++++++++++++++
 tb/tb_alu_modul.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_modul.sv
// Registered 32-bit I-type ALU: opcode decode, add/sub/logic/compare, carry/zero/overflow flags.
// Optional ALU_OVF_TRAP_EN: an overflowing ADDI keeps the previous Result and Zero.
module alu_modul (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OPCode,
  input  logic [31:0] Rs,
  input  logic [31:0] Rt,
  input  logic [31:0] Immediate,
  output logic [31:0] Result,
  output logic        carryOut,
  output logic        Zero,
  output logic        overFlow
);

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [31:0] imm_se_s;
  logic [31:0] imm_ze_s;
  logic        imm_hi_unused_s;
  logic [31:0] add_b_s;
  logic        add_cin_s;
  logic [32:0] sum_s;
  logic [31:0] alu_res_s;
  logic        alu_carry_s;
  logic        alu_ovf_s;
  logic        trap_hold_s;

  logic [31:0] result_d, result_q;
  logic        carry_d, carry_q;
  logic        zero_d, zero_q;
  logic        ovf_d, ovf_q;

  assign imm_se_s        = {{16{Immediate[15]}}, Immediate[15:0]};
  assign imm_ze_s        = {16'd0, Immediate[15:0]};
  assign imm_hi_unused_s = ^Immediate[31:16];

  // Shared adder operand select: branches subtract Rt, everything else adds SE.
  always_comb begin
    add_b_s   = imm_se_s;
    add_cin_s = 1'b0;
    case (OPCode)
      OP_BEQ, OP_BNE: begin
        add_b_s   = ~Rt;
        add_cin_s = 1'b1;
      end
      default: begin
        add_b_s   = imm_se_s;
        add_cin_s = 1'b0;
      end
    endcase
  end

  assign sum_s = add33(Rs, add_b_s, add_cin_s);

  // Opcode decode into the unregistered result and flags.
  always_comb begin
    alu_res_s   = 32'd0;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    trap_hold_s = 1'b0;
    case (OPCode)
      OP_ADDI: begin
        alu_res_s   = sum_s[31:0];
        alu_carry_s = sum_s[32];
        alu_ovf_s   = add_ovf(Rs[31], imm_se_s[31], sum_s[31]);
`ifdef ALU_OVF_TRAP_EN
        trap_hold_s = alu_ovf_s;
`else
        trap_hold_s = 1'b0;
`endif
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        alu_res_s   = sum_s[31:0];
        alu_carry_s = sum_s[32];
      end
      OP_BEQ, OP_BNE: begin
        // Carry out of Rs + ~Rt + 1 is the inverted borrow.
        alu_res_s   = sum_s[31:0];
        alu_carry_s = sum_s[32];
        alu_ovf_s   = add_ovf(Rs[31], add_b_s[31], sum_s[31]);
      end
      OP_ANDI:  alu_res_s = Rs & imm_ze_s;
      OP_ORI:   alu_res_s = Rs | imm_ze_s;
      OP_LUI:   alu_res_s = {Immediate[15:0], 16'd0};
      OP_SLTI:  alu_res_s = {31'd0, ($signed(Rs) < $signed(imm_se_s))};
      OP_SLTIU: alu_res_s = {31'd0, (Rs < imm_se_s)};
      default: begin
        alu_res_s   = 32'd0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
      end
    endcase
  end

  // Next-state for the output flops; a trapped ADDI leaves Result/Zero as they were.
  always_comb begin
    carry_d = alu_carry_s;
    ovf_d   = alu_ovf_s;
    if (trap_hold_s) begin
      result_d = result_q;
      zero_d   = zero_q;
    end else begin
      result_d = alu_res_s;
      zero_d   = (alu_res_s == 32'd0);
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Result   = result_q;
  assign carryOut = carry_q;
  assign Zero     = zero_q;
  assign overFlow = ovf_q;

endmodule

// File: tb/tb_alu_modul.sv
// Self-checking bench for alu_modul: directed vectors, random stimulus against an arithmetic model,
// back-to-back opcode switching and a mid-run asynchronous reset.
module tb_alu_modul;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OPCode;
  logic [31:0] Rs, Rt, Immediate;
  logic [31:0] Result;
  logic        carryOut, Zero, overFlow;

  int total = 0;
  int bad   = 0;

  // Expected {Result, carryOut, Zero, overFlow} after the most recent edge.
  logic [34:0] exp_v;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [34:0] exp;
  } vec_t;

  vec_t dir_v [12];

  logic [5:0] legal_ops [11];

  alu_modul dut (
    .clk(clk), .reset(reset), .OPCode(OPCode), .Rs(Rs), .Rt(Rt), .Immediate(Immediate),
    .Result(Result), .carryOut(carryOut), .Zero(Zero), .overFlow(overFlow)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic with signed range checks for overflow.
  function automatic logic [34:0] ref_alu(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] imm,
                                          input logic [34:0] prev);
    logic [31:0] se;
    logic [63:0] u;
    longint      s;
    logic [31:0] r;
    logic        c, o;
    se = {{16{imm[15]}}, imm[15:0]};
    r = 32'd0; c = 1'b0; o = 1'b0;
    case (op)
      6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
        u = {32'd0, rs} + {32'd0, se};
        s = longint'($signed(rs)) + longint'($signed(se));
        r = u[31:0];
        c = u[32];
        o = (op == 6'b001000) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      6'b000100, 6'b000101: begin
        r = rs - rt;
        c = (rs >= rt);
        s = longint'($signed(rs)) - longint'($signed(rt));
        o = (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      6'b001100: r = rs & {16'd0, imm[15:0]};
      6'b001101: r = rs | {16'd0, imm[15:0]};
      6'b001111: r = {imm[15:0], 16'd0};
      6'b001010: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
      6'b001011: r = (rs < se) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
`ifdef ALU_OVF_TRAP_EN
    if (op == 6'b001000 && o) return {prev[34:3], c, prev[1], 1'b1};
`endif
    return {r, c, (r == 32'd0), o};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm);
    @(negedge clk);
    OPCode = op; Rs = rs; Rt = rt; Immediate = imm;
    exp_v = ref_alu(op, rs, rt, imm, exp_v);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; OPCode = 6'd0; Rs = 32'd0; Rt = 32'd0; Immediate = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({Result, carryOut, Zero, overFlow} !== 35'd0) begin
      bad++;
      $display("FAIL reset_init: got %h required 0", {Result, carryOut, Zero, overFlow});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_v = 35'd0;
  endtask

  task automatic test_directed();
    dir_v[0]  = {6'b001000, 32'd0,          32'd0,      32'd46313,  {32'hFFFFB4E9, 3'b000}};
`ifdef ALU_OVF_TRAP_EN
    dir_v[1]  = {6'b001000, 32'h7FFFFFFF,   32'd0,      32'd1,      {32'hFFFFB4E9, 3'b001}};
`else
    dir_v[1]  = {6'b001000, 32'h7FFFFFFF,   32'd0,      32'd1,      {32'h80000000, 3'b001}};
`endif
    dir_v[2]  = {6'b001001, 32'hFFFFFFFF,   32'd0,      32'd45463,  {32'hFFFFB196, 3'b100}};
    dir_v[3]  = {6'b001100, 32'd11068,      32'd0,      32'd5313,   {32'h00000000, 3'b010}};
    dir_v[4]  = {6'b001111, 32'd0,          32'd0,      32'd46354,  {32'hB5120000, 3'b000}};
    dir_v[5]  = {6'b001011, 32'h80000000,   32'd0,      32'd4653,   {32'h00000000, 3'b010}};
    dir_v[6]  = {6'b001010, 32'hFFFFFFFA,   32'd0,      32'd468453, {32'h00000001, 3'b000}};
    dir_v[7]  = {6'b000100, 32'd1104345,    32'd106756, 32'd0,      {32'd997589,   3'b100}};
    dir_v[8]  = {6'b000101, 32'd14,         32'd14,     32'd0,      {32'h00000000, 3'b110}};
    dir_v[9]  = {6'b100011, 32'd14,         32'd0,      32'd2,      {32'd16,       3'b000}};
    dir_v[10] = {6'b101011, 32'd14,         32'd0,      32'd3,      {32'd17,       3'b000}};
    dir_v[11] = {6'b111111, 32'h12345678,   32'd9,      32'hFFFF,   {32'h00000000, 3'b010}};
    for (int i = 0; i < 12; i++) begin
      drive(dir_v[i].op, dir_v[i].rs, dir_v[i].rt, dir_v[i].imm);
      total++;
      if ({Result, carryOut, Zero, overFlow} !== dir_v[i].exp) begin
        bad++;
        $display("FAIL directed_%0d op=%b: got R=%h c=%b z=%b o=%b required R=%h c=%b z=%b o=%b",
                 i, dir_v[i].op, Result, carryOut, Zero, overFlow,
                 dir_v[i].exp[34:3], dir_v[i].exp[2], dir_v[i].exp[1], dir_v[i].exp[0]);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
      drive(op, rand_operand(), ($urandom_range(0, 3) == 0) ? Rs : rand_operand(), $urandom);
      total++;
      if ({Result, carryOut, Zero, overFlow} !== exp_v) begin
        bad++;
        $display("FAIL random op=%b Rs=%h Rt=%h Imm=%h: got %h_%b%b%b required %h_%b%b%b",
                 OPCode, Rs, Rt, Immediate, Result, carryOut, Zero, overFlow,
                 exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Alternate adder users with non-adder ops on consecutive edges.
    for (int i = 0; i < 40; i++) begin
      drive(legal_ops[i % 11], rand_operand(), rand_operand(), rand_operand());
      total++;
      if ({Result, carryOut, Zero, overFlow} !== exp_v) begin
        bad++;
        $display("FAIL back_to_back op=%b: got %h_%b%b%b required %h_%b%b%b", OPCode,
                 Result, carryOut, Zero, overFlow, exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    drive(6'b001001, 32'hFFFFFFFF, 32'd0, 32'h0000FFFF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({Result, carryOut, Zero, overFlow} !== 35'd0) begin
      bad++;
      $display("FAIL reset_async: got %h required 0", {Result, carryOut, Zero, overFlow});
    end
    OPCode = 6'b001111; Immediate = 32'h0000ABCD;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({Result, carryOut, Zero, overFlow} !== 35'd0) begin
      bad++;
      $display("FAIL reset_hold: got %h required 0", {Result, carryOut, Zero, overFlow});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_v = 35'd0;
  endtask

  initial begin
    legal_ops = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001111, 6'b001010,
                  6'b001011, 6'b000100, 6'b000101, 6'b100011, 6'b101011};
    exp_v = 35'd0;
    test_reset();
    test_directed();
    test_random(300);
    test_back_to_back();
    test_reset_midrun();
    test_random(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
